// File: rtl/kernel_bc_start_pkg.sv
// rtl/kernel_bc_start_pkg.sv - shared types and width helpers for the start-FIFO arbiter
`timescale 1ns/1ps
package kernel_bc_start_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    // Never returns less than 1 so single-value fields still get a bit.
    function automatic int clog2_min1(input int n);
        int w;
        for (w = 1; (1 << w) < n; w++) begin
        end
        return w;
    endfunction

    function automatic int id_width(input int num_req);
        return clog2_min1(num_req);
    endfunction

    function automatic int cnt_width(input int max_out);
        return clog2_min1(max_out + 1);
    endfunction

    localparam int TAG_ID_W   = 2;
    localparam int TAG_DATA_W = 1;

    typedef struct packed {
        logic [TAG_ID_W-1:0]   id;
        logic [TAG_DATA_W-1:0] payload;
    } start_tag_t;

endpackage

// File: rtl/kernel_bc_rr_pick.sv
// rtl/kernel_bc_rr_pick.sv - combinational round-robin winner search
`timescale 1ns/1ps
module kernel_bc_rr_pick
    import kernel_bc_start_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic               en,
    input  logic [NUM_REQ-1:0] elig,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);

    int start;
    int idx;

    // Wrap is an explicit compare so non-power-of-two NUM_REQ rotates correctly.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        start     = (int'(rr_ptr) >= NUM_REQ - 1) ? 0 : int'(rr_ptr) + 1;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = start + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (en && !grant_any && elig[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/kernel_bc_start_fifo_arb.sv
// rtl/kernel_bc_start_fifo_arb.sv - round-robin sharing of the write_back start FIFO write port
`timescale 1ns/1ps
module kernel_bc_start_fifo_arb
    import kernel_bc_start_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 1,
    parameter int ID_W       = id_width(NUM_REQ),
    parameter int MAX_OUT    = 4,
    parameter int CNT_W      = cnt_width(MAX_OUT)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic                          fifo_write,
    output logic                          fifo_write_ce,
    output logic [ID_W+DATA_WIDTH-1:0]    fifo_din,
    input  logic                          fifo_full_n,
    input  logic                          ret_valid,
    input  logic [ID_W-1:0]               ret_id,
    output logic                          busy,
    output logic                          err_underflow
);

    arb_state_e                 state_q, state_d;
    logic                       out_valid_q, out_valid_d;
    logic [ID_W+DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]           credit_q [NUM_REQ];
    logic [CNT_W-1:0]           credit_d [NUM_REQ];
    logic                       err_q, err_d;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_id;
    logic               win_any;
    logic               load_ok;
    logic               retire;
    logic               arb_en;
    logic               ret_in_range;
    logic               any_credit;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && (credit_q[i] < CNT_W'(MAX_OUT));
        end
    end

    // A held entry that retires this cycle frees the slot for a same-cycle reload.
    assign retire  = out_valid_q && fifo_full_n;
    assign load_ok = !out_valid_q || fifo_full_n;
    assign arb_en  = !reset && (state_q == ST_RUN) && load_ok;

    kernel_bc_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .en        (arb_en),
        .elig      (elig),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_id  (win_id),
        .grant_any (win_any)
    );

    assign req_grant     = grant;
    assign fifo_write    = out_valid_q && !reset;
    assign fifo_write_ce = 1'b1;
    assign fifo_din      = out_data_q;
    assign err_underflow = err_q;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            ST_IDLE:  if (cfg_enable) state_d = ST_RUN;
            ST_RUN:   if (!cfg_enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (cfg_enable) begin
                    state_d = ST_RUN;
                end else if (!out_valid_q) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
        if (win_any) begin
            out_valid_d = 1'b1;
            out_data_d  = {win_id, req_data[win_id*DATA_WIDTH +: DATA_WIDTH]};
            rr_ptr_d    = win_id;
        end else if (retire) begin
            out_valid_d = 1'b0;
        end
    end

    assign ret_in_range = {1'b0, ret_id} < (ID_W+1)'(NUM_REQ);

    // Same-id grant and return cancel; a return with nothing outstanding only flags.
    always_comb begin
        err_d      = err_q;
        any_credit = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            credit_d[i] = credit_q[i];
            any_credit  = any_credit | (credit_q[i] != '0);
            if (ret_valid && ret_in_range && (ret_id == ID_W'(i))) begin
                if (credit_q[i] == '0) begin
                    err_d = 1'b1;
                end
                if (!grant[i] && (credit_q[i] != '0)) begin
                    credit_d[i] = credit_q[i] - CNT_W'(1);
                end
            end else if (grant[i]) begin
                credit_d[i] = credit_q[i] + CNT_W'(1);
            end
        end
        if (ret_valid && !ret_in_range) begin
            err_d = 1'b1;
        end
    end

    assign busy = (state_q != ST_IDLE) || any_credit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                credit_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rr_ptr_q    <= rr_ptr_d;
            err_q       <= err_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

endmodule

// File: tb/tb_kernel_bc_start_fifo_arb.sv
// tb/tb_kernel_bc_start_fifo_arb.sv - self-checking bench for kernel_bc_start_fifo_arb
`timescale 1ns/1ps
module tb_kernel_bc_start_fifo_arb;
    import kernel_bc_start_pkg::*;

    localparam int NR = 4;
    localparam int MO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_enable;
    logic [3:0] req_valid;
    logic [3:0] req_data;
    logic [3:0] req_grant;
    logic       fifo_write;
    logic       fifo_write_ce;
    logic [2:0] fifo_din;
    logic       fifo_full_n;
    logic       ret_valid;
    logic [1:0] ret_id;
    logic       busy;
    logic       err_underflow;

    kernel_bc_start_fifo_arb dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_enable    (cfg_enable),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_grant     (req_grant),
        .fifo_write    (fifo_write),
        .fifo_write_ce (fifo_write_ce),
        .fifo_din      (fifo_din),
        .fifo_full_n   (fifo_full_n),
        .ret_valid     (ret_valid),
        .ret_id        (ret_id),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 run, 2 drain; held token as a flag plus tag.
    int         m_state;
    int         m_cred [NR];
    int         m_rr;
    bit         m_held;
    logic [2:0] m_din;
    bit         m_err;

    logic [3:0] exp_grant;
    logic       exp_write;
    logic [2:0] exp_din;
    logic       exp_busy;
    logic       exp_err;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_eval();
        bit load_ok;
        bit any;
        int i;
        load_ok   = !m_held || fifo_full_n;
        exp_grant = '0;
        if (!reset && m_state == 1 && load_ok) begin
            for (int k = 1; k <= NR; k++) begin
                i = (m_rr + k) % NR;
                if (exp_grant == 0 && req_valid[i] && m_cred[i] < MO) exp_grant[i] = 1'b1;
            end
        end
        any = 0;
        for (int j = 0; j < NR; j++) if (m_cred[j] != 0) any = 1;
        exp_write = m_held && !reset;
        exp_din   = m_din;
        exp_busy  = (m_state != 0) || any;
        exp_err   = m_err;
    endtask

    task automatic model_commit();
        int win;
        bit inc;
        bit dec;
        start_tag_t t;
        win = -1;
        for (int i = 0; i < NR; i++) if (exp_grant[i]) win = i;
        if (reset) begin
            m_state = 0; m_rr = NR - 1; m_held = 0; m_din = '0; m_err = 0;
            for (int i = 0; i < NR; i++) m_cred[i] = 0;
            return;
        end
        for (int i = 0; i < NR; i++) begin
            inc = (win == i);
            dec = ret_valid && (ret_id == i);
            if (dec && m_cred[i] == 0) m_err = 1;
            if (inc && !dec) m_cred[i] = m_cred[i] + 1;
            else if (dec && !inc && m_cred[i] > 0) m_cred[i] = m_cred[i] - 1;
        end
        case (m_state)
            0: if (cfg_enable) m_state = 1;
            1: if (!cfg_enable) m_state = 2;
            default: if (cfg_enable) m_state = 1; else if (!m_held) m_state = 0;
        endcase
        if (win >= 0) begin
            t.id      = 2'(win);
            t.payload = req_data[win];
            m_din     = t;
            m_held    = 1;
            m_rr      = win;
        end else if (m_held && fifo_full_n) begin
            m_held = 0;
        end
    endtask

    task automatic settle();
        #2;
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; cfg_enable = 1'b0; req_valid = '0; ret_valid = 1'b0; ret_id = '0;
        fifo_full_n = 1'b1;
        repeat (2) begin settle(); advance(); end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_enable = 1'b1; req_valid = 4'hF; req_data = 4'hA;
        fifo_full_n = 1'b1; ret_valid = 1'b0; ret_id = '0;
        settle();
        n_checks++; if (req_grant !== 4'b0) begin n_fail++; $display("FAIL rst_grant got=%b exp=0000", req_grant); end
        n_checks++; if (fifo_write !== 1'b0) begin n_fail++; $display("FAIL rst_write got=%b exp=0", fifo_write); end
        advance();
        settle(); advance();
        reset = 1'b0; cfg_enable = 1'b0;
        settle();
        n_checks++; if (fifo_din !== 3'b0) begin n_fail++; $display("FAIL rst_din got=%h exp=0", fifo_din); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err_underflow); end
        n_checks++; if (fifo_write_ce !== 1'b1) begin n_fail++; $display("FAIL write_ce got=%b exp=1", fifo_write_ce); end
        advance();
    endtask

    task automatic test_fairness();
        int  gi;
        bit  prev_w;
        logic [1:0] prev_id;
        apply_reset();
        cfg_enable = 1'b1; req_valid = 4'hF; fifo_full_n = 1'b1;
        gi = 0; prev_w = 0; prev_id = '0;
        for (int c = 0; c < 14; c++) begin
            ret_valid = prev_w; ret_id = prev_id; req_data = 4'($urandom);
            settle();
            n_checks++; if (req_grant !== exp_grant) begin n_fail++; $display("FAIL fair_model c=%0d got=%b exp=%b", c, req_grant, exp_grant); end
            if (c >= 1) begin
                n_checks++;
                if (req_grant !== 4'(1 << (gi % 4))) begin n_fail++; $display("FAIL fair_order c=%0d got=%b exp=%b", c, req_grant, 4'(1 << (gi % 4))); end
                gi++;
            end
            if (c >= 2) begin
                n_checks++; if (fifo_write !== 1'b1 || fifo_din !== exp_din) begin n_fail++; $display("FAIL fair_write c=%0d got=%b/%h exp=1/%h", c, fifo_write, fifo_din, exp_din); end
            end
            prev_w = exp_write; prev_id = exp_din[2:1];
            advance();
        end
        ret_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic d;
        int   grants;
        apply_reset();
        d = 1'($urandom);
        cfg_enable = 1'b1; req_valid = 4'b0001; req_data = {3'b0, d}; fifo_full_n = 1'b0;
        grants = 0;
        for (int c = 0; c < 7; c++) begin
            settle();
            n_checks++; if (req_grant !== exp_grant) begin n_fail++; $display("FAIL bp_model c=%0d got=%b exp=%b", c, req_grant, exp_grant); end
            if (req_grant[0]) grants++;
            if (c >= 2) begin
                n_checks++; if (fifo_write !== 1'b1 || fifo_din !== {2'd0, d}) begin n_fail++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h", c, fifo_write, fifo_din, {2'd0, d}); end
            end
            advance();
        end
        n_checks++; if (grants != 1) begin n_fail++; $display("FAIL bp_grants got=%0d exp=1", grants); end
        fifo_full_n = 1'b1;
        settle();
        n_checks++; if (req_grant !== 4'b0001 || fifo_write !== 1'b1) begin n_fail++; $display("FAIL bp_b2b got=%b/%b exp=0001/1", req_grant, fifo_write); end
        advance();
    endtask

    task automatic test_credit_limit();
        int grants;
        apply_reset();
        cfg_enable = 1'b1; req_valid = 4'b0100; req_data = 4'hF; fifo_full_n = 1'b1;
        grants = 0;
        for (int c = 0; c < 10; c++) begin
            settle();
            n_checks++; if (req_grant !== exp_grant) begin n_fail++; $display("FAIL cl_model c=%0d got=%b exp=%b", c, req_grant, exp_grant); end
            if (req_grant[2]) grants++;
            advance();
        end
        n_checks++; if (grants != 4) begin n_fail++; $display("FAIL cl_grants got=%0d exp=4", grants); end
        ret_valid = 1'b1; ret_id = 2'd2;
        settle();
        n_checks++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL cl_ret_cycle got=%b exp=0000", req_grant); end
        advance();
        ret_valid = 1'b0;
        settle();
        n_checks++; if (req_grant !== 4'b0100) begin n_fail++; $display("FAIL cl_regrant got=%b exp=0100", req_grant); end
        advance();
        settle();
        n_checks++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL cl_full_again got=%b exp=0000", req_grant); end
        advance();
    endtask

    task automatic test_simultaneous();
        int grants;
        apply_reset();
        cfg_enable = 1'b1; req_valid = 4'b0010; req_data = 4'h0; fifo_full_n = 1'b1;
        settle(); advance();
        settle();
        n_checks++; if (req_grant !== 4'b0010) begin n_fail++; $display("FAIL sim_first got=%b exp=0010", req_grant); end
        advance();
        ret_valid = 1'b1; ret_id = 2'd1;
        settle();
        n_checks++; if (req_grant !== 4'b0010) begin n_fail++; $display("FAIL sim_both got=%b exp=0010", req_grant); end
        advance();
        ret_valid = 1'b0;
        grants = 0;
        for (int c = 0; c < 8; c++) begin
            settle();
            if (req_grant[1]) grants++;
            advance();
        end
        n_checks++; if (grants != 3) begin n_fail++; $display("FAIL sim_credit grants=%0d exp=3", grants); end
        ret_valid = 1'b1; ret_id = 2'd3;
        settle();
        n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_before got=%b exp=0", err_underflow); end
        advance();
        ret_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            n_checks++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky c=%0d got=%b exp=1", c, err_underflow); end
            advance();
        end
        apply_reset();
        settle();
        n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_clear got=%b exp=0", err_underflow); end
        advance();
    endtask

    task automatic test_disable();
        apply_reset();
        cfg_enable = 1'b1; req_valid = 4'b0001; req_data = 4'h1; fifo_full_n = 1'b0;
        settle(); advance();
        settle(); advance();
        cfg_enable = 1'b0;
        settle(); advance();
        for (int c = 0; c < 3; c++) begin
            settle();
            n_checks++; if (req_grant !== 4'b0 || fifo_write !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL dis_drain c=%0d got=%b/%b/%b exp=0000/1/1", c, req_grant, fifo_write, busy); end
            advance();
        end
        fifo_full_n = 1'b1;
        settle();
        n_checks++; if (fifo_write !== 1'b1 || fifo_din !== 3'b001) begin n_fail++; $display("FAIL dis_write got=%b/%h exp=1/1", fifo_write, fifo_din); end
        advance();
        settle();
        n_checks++; if (fifo_write !== 1'b0 || req_grant !== 4'b0) begin n_fail++; $display("FAIL dis_done got=%b/%b exp=0/0000", fifo_write, req_grant); end
        advance();
        settle();
        n_checks++; if (busy !== 1'b1 || busy !== exp_busy) begin n_fail++; $display("FAIL dis_busy_credit got=%b exp=1", busy); end
        ret_valid = 1'b1; ret_id = 2'd0;
        advance();
        ret_valid = 1'b0;
        settle();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dis_idle got=%b exp=0", busy); end
        advance();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        cfg_enable = 1'b1; req_valid = 4'hF; req_data = 4'h5; fifo_full_n = 1'b0;
        settle(); advance();
        settle(); advance();
        settle();
        n_checks++; if (fifo_write !== 1'b1) begin n_fail++; $display("FAIL rm_held got=%b exp=1", fifo_write); end
        advance();
        reset = 1'b1;
        settle();
        n_checks++; if (fifo_write !== 1'b0) begin n_fail++; $display("FAIL rm_rst_cycle got=%b exp=0", fifo_write); end
        advance();
        reset = 1'b0; fifo_full_n = 1'b1;
        settle();
        n_checks++; if (fifo_write !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_after got=%b/%b exp=0/0", fifo_write, busy); end
        advance();
        settle();
        n_checks++; if (req_grant !== 4'b0001) begin n_fail++; $display("FAIL rm_rrptr got=%b exp=0001", req_grant); end
        advance();
    endtask

    task automatic test_random();
        int id;
        apply_reset();
        cfg_enable = 1'b1;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(63) == 0);
            if ($urandom_range(15) == 0) cfg_enable = ~cfg_enable;
            req_valid   = 4'($urandom);
            req_data    = 4'($urandom);
            fifo_full_n = ($urandom_range(3) != 0);
            ret_valid   = 1'b0;
            id = $urandom_range(NR - 1);
            if ($urandom_range(1) == 1 && m_cred[id] > 0) begin
                ret_valid = 1'b1; ret_id = 2'(id);
            end
            settle();
            n_checks++; if (req_grant !== exp_grant) begin n_fail++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, req_grant, exp_grant); end
            n_checks++; if (fifo_write !== exp_write) begin n_fail++; $display("FAIL rnd_write c=%0d got=%b exp=%b", c, fifo_write, exp_write); end
            if (exp_write) begin
                n_checks++; if (fifo_din !== exp_din) begin n_fail++; $display("FAIL rnd_din c=%0d got=%h exp=%h", c, fifo_din, exp_din); end
            end
            n_checks++; if (busy !== exp_busy || err_underflow !== exp_err) begin n_fail++; $display("FAIL rnd_status c=%0d got=%b/%b exp=%b/%b", c, busy, err_underflow, exp_busy, exp_err); end
            advance();
        end
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cfg_enable = 1'b0; req_valid = '0; req_data = '0;
        fifo_full_n = 1'b1; ret_valid = 1'b0; ret_id = '0;
        m_state = 0; m_rr = NR - 1; m_held = 0; m_din = '0; m_err = 0;
        for (int i = 0; i < NR; i++) m_cred[i] = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_fairness();
        test_backpressure();
        test_credit_limit();
        test_simultaneous();
        test_disable();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kernel_bc_start_fifo_arb.md
Name: kernel_bc_start_fifo_arb

Overview:
Round-robin arbiter that shares the single write port of the write_back start FIFO among NUM_REQ upstream dataflow processes.
- Each accepted start token is tagged with its requester id and passed through a one-entry registered output stage.
- Per-requester credit counters limit how many tokens each source has outstanding until write_back returns a completion for that id.
- Sits between the producer processes' start outputs and the start FIFO's if_write/if_din/if_full_n interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 1, start-token payload width
ID_W, 2, requester id width, equal to clog2(NUM_REQ)
MAX_OUT, 4, maximum outstanding tokens per requester (1..7)
CNT_W, 3, credit counter width, equal to clog2(MAX_OUT+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_enable  in  1  arbitration enable
req_valid  in  NUM_REQ  per-requester token request
req_data  in  NUM_REQ*DATA_WIDTH  payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_grant  out  NUM_REQ  one-hot accept pulse; the token is consumed in this cycle
fifo_write  out  1  to FIFO if_write
fifo_write_ce  out  1  to FIFO if_write_ce; constant 1
fifo_din  out  ID_W+DATA_WIDTH  {id, payload} to FIFO if_din
fifo_full_n  in  1  from FIFO if_full_n
ret_valid  in  1  completion return from write_back
ret_id  in  ID_W  id of the completed token
busy  out  1  state != IDLE, or any credit counter nonzero
err_underflow  out  1  sticky flag: a return arrived for an id with zero outstanding

Behaviour:
- Reset values:
  - state=IDLE, out_valid=0, fifo_write=0, fifo_din=0, req_grant=0.
  - All credit counters=0, rr_ptr=NUM_REQ-1, err_underflow=0.
  - Reset mid-transfer discards any held token; no write is issued in the reset cycle or the cycle after.
- States:
  - IDLE -> RUN when cfg_enable=1.
  - RUN -> DRAIN when cfg_enable=0.
  - DRAIN -> IDLE when out_valid=0; DRAIN -> RUN if cfg_enable returns to 1 first.
  - Grants are issued only in RUN.
- Output stage:
  - fifo_write = out_valid; fifo_din holds the registered {id, payload}.
  - The entry retires in any cycle where out_valid=1 and fifo_full_n=1.
  - Load is allowed when out_valid=0, or when out_valid=1 and fifo_full_n=1 in the same cycle, giving back-to-back writes with no bubble.
  - When the FIFO is full (fifo_full_n=0): fifo_write and fifo_din stay stable until accepted.
- Eligibility: requester i is eligible when req_valid[i]=1 and credit[i] < MAX_OUT.
- Arbitration:
  - Combinational search starting at (rr_ptr+1) mod NUM_REQ, wrapping around.
  - On a grant, rr_ptr <= winner. After reset, requester 0 has highest priority.
- Latency: req_grant pulse in cycle N; fifo_write=1 with that token in cycle N+1.
- Credits:
  - credit[i] +1 on grant to i.
  - credit[ret_id] -1 on ret_valid.
  - Grant and return to the same id in the same cycle: counter unchanged.
  - Return with credit=0: counter stays 0 and err_underflow is set; only reset clears it.
  - ret_id >= NUM_REQ: ignored and sets err_underflow.
  - Counters saturate by construction, since eligibility blocks grants at MAX_OUT.
- Returns are processed in every state, including IDLE.
- NUM_REQ not a power of two: rr_ptr wrap uses an explicit compare, not bit truncation.

Decomposition:
- Shared package kernel_bc_start_pkg holds:
  - state enum (IDLE, RUN, DRAIN)
  - ID_W / CNT_W derivation functions
  - token tag struct {id, payload}
- One natural sub-module: kernel_bc_rr_pick. It is purely combinational and computes the one-hot winner from the eligibility vector and rr_ptr.
- Credit counters and the output register stay in the top level.

Test Plan:
- Fairness: NUM_REQ=4, all req_valid=1 held, fifo_full_n=1, ret_valid tied to each write's id one cycle later -> grants cycle 0,1,2,3,0,1,... with one fifo_write per cycle.
- Back-pressure: fifo_full_n=0 for 5 cycles while req0 asserts -> exactly one grant; fifo_write=1 with fifo_din={0,d} stable for 5 cycles; no further grant until fifo_full_n=1.
- Credit limit: MAX_OUT=4, req2 alone with no returns -> 4 grants, then credit[2]=4 and no grant. One ret_valid with ret_id=2 -> one more grant the next cycle.
- Simultaneous events: grant to req1 and ret_valid with ret_id=1 in the same cycle -> credit[1] unchanged. A return for id 3 with credit 0 -> err_underflow=1, persisting until reset.
- Disable mid-operation: held token with fifo_full_n=0, cfg_enable drops -> state=DRAIN, no new grants. fifo_full_n=1 -> token written, state=IDLE, busy follows the credits.
- Reset mid-transfer: out_valid=1 and FIFO full, assert reset -> fifo_write=0 the next cycle, all credits 0, rr_ptr=3.
